// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_ALIGN_CHECK_EN selects halting on misaligned targets (see fetch_next_pc).
package instruction_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  localparam word_t PC_INCR = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_fetch_next_pc.sv
// Next-PC selection (Jump > PC_Scr > sequential) and misalignment detection.
// With FETCH_ALIGN_CHECK_EN defined a target with low bits set is flagged; otherwise it is word-aligned.
module fetch_next_pc
  import instruction_fetch_unit_pkg::*;
(
  input  word_t pc,
  input  logic  jump,
  input  logic  pc_scr,
  input  word_t pc_jump,
  input  word_t pc_branch,
  output word_t next_pc,
  output logic  misaligned
);

  word_t target;

  always_comb begin
    target = pc + PC_INCR;
    if (jump) begin
      target = pc_jump;
    end else if (pc_scr) begin
      target = pc_branch;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign next_pc    = target;
  assign misaligned = |target[1:0];
`else
  // Without the check the low bits are simply dropped, so HALT can never be entered.
  assign next_pc    = target & ~32'h3;
  assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding-request instruction fetch unit: REQ -> HOLD -> REQ, HALT on a bad target.
// Optional FETCH_ALIGN_CHECK_EN enables the misaligned-target halt.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output word_t        imem_addr,
  input  logic         imem_ready,
  input  word_t        imem_rdata,
  output word_t        Instruction,
  output word_t        PC_Plus4,
  output logic         instr_valid,
  input  logic         instr_accept,
  input  logic         Jump,
  input  logic         PC_Scr,
  input  word_t        PC_Jump,
  input  word_t        PC_Branch,
  output word_t        fetch_count,
  output logic         fetch_err,
  output fetch_state_t state_dbg
);

  // Handshakes: a fetch completes on imem_req && imem_ready (req/addr stable until then);
  // an instruction is consumed on instr_valid && instr_accept. Either side alone is ignored.

  fetch_state_t state, state_nxt;
  word_t        pc, next_pc;
  logic         misaligned;
  logic         fetch_done, accept_done;

  fetch_next_pc u_next_pc (
    .pc         (pc),
    .jump       (Jump),
    .pc_scr     (PC_Scr),
    .pc_jump    (PC_Jump),
    .pc_branch  (PC_Branch),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      S_REQ: begin
        // Gated by rst_n so no request is visible while reset is asserted.
        imem_req = rst_n;
        if (imem_ready) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_accept) state_nxt = misaligned ? S_HALT : S_REQ;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_REQ;
    endcase
  end

  assign fetch_done  = imem_req && imem_ready;
  assign accept_done = instr_valid && instr_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      Instruction <= '0;
      PC_Plus4    <= '0;
      fetch_count <= '0;
      fetch_err   <= 1'b0;
    end else begin
      if (fetch_done) begin
        Instruction <= imem_rdata;
        PC_Plus4    <= pc + PC_INCR;
      end
      if (accept_done) begin
        pc          <= next_pc;
        fetch_count <= fetch_count + 32'd1;
        if (misaligned) fetch_err <= 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign state_dbg = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (either FETCH_ALIGN_CHECK_EN build).
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         imem_req;
  word_t        imem_addr;
  logic         imem_ready;
  word_t        imem_rdata;
  word_t        Instruction;
  word_t        PC_Plus4;
  logic         instr_valid;
  logic         instr_accept;
  logic         Jump;
  logic         PC_Scr;
  word_t        PC_Jump;
  word_t        PC_Branch;
  word_t        fetch_count;
  logic         fetch_err;
  fetch_state_t state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .PC_Plus4     (PC_Plus4),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .Jump         (Jump),
    .PC_Scr       (PC_Scr),
    .PC_Jump      (PC_Jump),
    .PC_Branch    (PC_Branch),
    .fetch_count  (fetch_count),
    .fetch_err    (fetch_err),
    .state_dbg    (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t mem_word(input word_t a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: entered and left at a falling edge; inputs change there, outputs are sampled there.
  task automatic fetch(input word_t exp_addr, input word_t exp_count);
    check("req_on", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_addr);
    imem_ready = 1'b1;
    imem_rdata = mem_word(exp_addr);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check("valid", {31'd0, instr_valid}, 32'd1);
    check("req_off", {31'd0, imem_req}, 32'd0);
    check("instr", Instruction, mem_word(exp_addr));
    check("pc_plus4", PC_Plus4, exp_addr + 32'd4);
    check("count_hold", fetch_count, exp_count);
  endtask

  task automatic accept(input logic j, input logic s, input word_t pj, input word_t pb);
    instr_accept = 1'b1;
    Jump      = j;
    PC_Scr    = s;
    PC_Jump   = pj;
    PC_Branch = pb;
    @(negedge clk);
    instr_accept = 1'b0;
    Jump      = 1'b0;
    PC_Scr    = 1'b0;
    PC_Jump   = 32'h0;
    PC_Branch = 32'h0;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_pc4", PC_Plus4, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    imem_ready   = 1'b0;
    imem_rdata   = 32'h0;
    instr_accept = 1'b0;
    Jump         = 1'b0;
    PC_Scr       = 1'b0;
    PC_Jump      = 32'h0;
    PC_Branch    = 32'h0;
    @(negedge clk);
    reset_pulse();
    check("state_req", {30'd0, state_dbg}, {30'd0, S_REQ});

    // Sequential fetches 0,4,8
    fetch(32'h0, 32'd0);
    check("state_hold", {30'd0, state_dbg}, {30'd0, S_HOLD});
    accept(1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h4, 32'd1);
    accept(1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h8, 32'd2);
    accept(1'b0, 1'b0, 32'h0, 32'h0);
    check("count3", fetch_count, 32'd3);
    fetch(32'hC, 32'd3);
    accept(1'b1, 1'b0, 32'h10, 32'h0);

    // Memory stalls three cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, 32'h10);
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    fetch(32'h10, 32'd4);

    // Held in HOLD; a stray imem_ready without a request must not recapture
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_instr", Instruction, mem_word(32'h10));
      check("hold_pc4", PC_Plus4, 32'h14);
      check("hold_count", fetch_count, 32'd4);
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ready = 1'b0;
    imem_rdata = 32'h0;

    // Jump wins over branch; then branch alone
    accept(1'b1, 1'b1, 32'h40, 32'h80);
    check("jump_prio", imem_addr, 32'h40);
    fetch(32'h40, 32'd5);
    accept(1'b0, 1'b1, 32'h40, 32'h80);
    check("branch", imem_addr, 32'h80);
    fetch(32'h80, 32'd6);
    accept(1'b0, 1'b0, 32'h40, 32'h0);

    // Accept without a valid instruction is ignored
    instr_accept = 1'b1;
    Jump = 1'b1;
    PC_Jump = 32'h200;
    @(negedge clk);
    @(negedge clk);
    instr_accept = 1'b0;
    Jump = 1'b0;
    PC_Jump = 32'h0;
    check("idle_accept_count", fetch_count, 32'd7);
    check("idle_accept_addr", imem_addr, 32'h84);
    fetch(32'h84, 32'd7);

    // Address wrap at the top of memory
    accept(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    fetch(32'hFFFF_FFFC, 32'd8);
    check("wrap_pc4", PC_Plus4, 32'h0);
    accept(1'b0, 1'b0, 32'h0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    fetch(32'h0, 32'd9);

    // Misaligned jump target
    accept(1'b1, 1'b0, 32'h42, 32'h0);
    check("mis_count", fetch_count, 32'd10);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check("halt_err", {31'd0, fetch_err}, 32'd1);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("halt_state", {30'd0, state_dbg}, {30'd0, S_HALT});
`else
    check("align_addr", imem_addr, 32'h40);
    check("align_err", {31'd0, fetch_err}, 32'd0);
    check("align_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
`endif

    // Reset discards any outstanding state; fetching restarts at RESET_PC
    reset_pulse();
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_err", {31'd0, fetch_err}, 32'd0);
    fetch(32'h0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  byte address of requested word.
REQ-006 imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 Instruction  output  32  held instruction for the processor.
REQ-009 PC_Plus4  output  32  address of Instruction plus 4.
REQ-010 instr_valid  output  1  Instruction/PC_Plus4 are valid.
REQ-011 instr_accept  input  1  processor consumes the current instruction this cycle.
REQ-012 Jump, PC_Scr  input  1 each  redirect selects from the processor.
REQ-013 PC_Jump, PC_Branch  input  32 each  redirect targets.
REQ-014 fetch_count  output  32  number of accepted instructions.
REQ-015 fetch_err  output  1  sticky misaligned-target flag.

Function
REQ-016 FSM states: REQ, HOLD, HALT; every transition occurs on the rising clk edge.
REQ-017 REQ: imem_req=1 and imem_addr=pc; both stay stable until imem_req && imem_ready.
REQ-018 REQ with imem_ready=1: capture imem_rdata into Instruction, set PC_Plus4=pc+4 (mod 2^32), go to HOLD.
REQ-019 HOLD: instr_valid=1, imem_req=0, outputs stable while instr_accept=0.
REQ-020 HOLD with instr_accept=1: next pc = Jump ? PC_Jump : (PC_Scr ? PC_Branch : pc+4), fetch_count+1, go to REQ.
REQ-021 Jump has priority over PC_Scr when both are 1; redirect inputs are sampled only when accepting in HOLD.
REQ-022 instr_accept while instr_valid=0 is ignored.
REQ-023 Latency: accept in cycle N → imem_req in N+1; imem_ready in N+1 → instr_valid in N+2.
REQ-024 pc+4 from 32'hFFFF_FFFC wraps to 32'h0; fetch_count wraps from 32'hFFFF_FFFF to 0.
REQ-025 imem_ready while imem_req=0 is ignored.

Reset
REQ-026 rst_n low forces state REQ, pc=RESET_PC, Instruction=0, PC_Plus4=0, fetch_count=0, fetch_err=0, instr_valid=0; imem_req=0 while rst_n is low.
REQ-027 Reset mid-request discards the outstanding fetch; the first request after rst_n rises uses RESET_PC.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN defined: next pc with bits [1:0]≠0 → HALT, fetch_err=1, imem_req=0, instr_valid=0; exit from HALT only by reset.
REQ-029 Macro undefined: pc[1:0] forced to 0 on every update, fetch_err tied 0, HALT unreachable.

Structure
REQ-030 Shared package holds FSM state encoding, a 32-bit word typedef, and constant PC_INCR=4.
REQ-031 One combinational sub-module fetch_next_pc implements the REQ-020/021 selection and alignment detection.

Verification
REQ-032 Reset, imem_ready=1 always, accept every HOLD → imem_addr sequence 0,4,8; PC_Plus4 sequence 4,8,12; fetch_count=3.
REQ-033 imem_ready low for 3 cycles at addr 32'h10 → imem_req and imem_addr=32'h10 held 4 cycles, single capture.
REQ-034 Accept with Jump=1, PC_Jump=32'h40, PC_Scr=1, PC_Branch=32'h80 → next imem_addr=32'h40.
REQ-035 instr_accept=0 for 5 cycles in HOLD → Instruction, PC_Plus4, fetch_count unchanged; no imem_req.
REQ-036 Macro defined, accept with Jump=1, PC_Jump=32'h42 → fetch_err=1, imem_req=0 until reset; rst_n pulse → request at RESET_PC, fetch_err=0.
